// File: rtl/config_loader.sv
// Bitstream loader: accepts bytes over a valid/ready handshake and shifts them MSB-first
// into the tile config chain. Optional CRC-16-CCITT trailer check under CONFIG_LOADER_CRC_EN.
module config_loader #(
    parameter int CHAIN_LENGTH = 216
) (
    input  logic       config_clock,
    input  logic       config_reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       config_in,
    output logic       config_enable,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LENGTH - 1);

`ifdef CONFIG_LOADER_CRC_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CRC, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] bit_count;
    logic [2:0]       bit_index;
    logic [7:0]       shift_reg;
    logic             last_bit;
    logic             byte_end;

    assign last_bit = (bit_count == LAST_BIT);
    assign byte_end = (bit_index == 3'd7);

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] crc;
    logic [7:0]  trailer_hi;
    logic        trailer_count;
    logic        crc_error;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic feedback;
        feedback = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (feedback ? 16'h1021 : 16'h0000);
    endfunction
`endif

    always_ff @(posedge config_clock) begin
        if (config_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = LOAD;
            LOAD:       if (data_valid) next_state = SHIFT;
            SHIFT: begin
                // Chain exhaustion wins over the byte boundary so a partial last byte ends the load.
                if (last_bit) begin
`ifdef CONFIG_LOADER_CRC_EN
                    next_state = CRC;
`else
                    next_state = DONE;
`endif
                end else if (byte_end) begin
                    next_state = LOAD;
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            CRC:        if (data_valid && trailer_count) next_state = DONE;
`endif
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge config_clock) begin
        if (config_reset) begin
            bit_count <= '0;
            bit_index <= '0;
            shift_reg <= '0;
`ifdef CONFIG_LOADER_CRC_EN
            crc           <= '0;
            trailer_hi    <= '0;
            trailer_count <= 1'b0;
            crc_error     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bit_count <= '0;
                        bit_index <= '0;
`ifdef CONFIG_LOADER_CRC_EN
                        crc           <= 16'hFFFF;
                        trailer_count <= 1'b0;
                        crc_error     <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (data_valid) begin
                        shift_reg <= data_in;
                        bit_index <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    bit_count <= bit_count + CNT_W'(1);
                    bit_index <= bit_index + 3'd1;
`ifdef CONFIG_LOADER_CRC_EN
                    crc <= crc16_step(crc, shift_reg[7]);
`endif
                end
`ifdef CONFIG_LOADER_CRC_EN
                CRC: begin
                    if (data_valid) begin
                        if (!trailer_count) begin
                            trailer_hi    <= data_in;
                            trailer_count <= 1'b1;
                        end else begin
                            crc_error <= ({trailer_hi, data_in} != crc);
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        data_ready    = 1'b0;
        config_enable = 1'b0;
        config_in     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            LOAD: begin
                data_ready = 1'b1;
                busy       = 1'b1;
            end
            SHIFT: begin
                config_enable = 1'b1;
                config_in     = shift_reg[7];
                busy          = 1'b1;
            end
`ifdef CONFIG_LOADER_CRC_EN
            CRC: begin
                data_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            DONE:    done = 1'b1;
            default: begin
            end
        endcase
    end

`ifdef CONFIG_LOADER_CRC_EN
    assign error = crc_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: a cycle model of the load protocol is compared against two
// loader instances every cycle, backed by literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_config_loader;

`ifdef CONFIG_LOADER_CRC_EN
    localparam int  L0     = 8;
    localparam bit  CRC_ON = 1'b1;
`else
    localparam int  L0     = 24;
    localparam bit  CRC_ON = 1'b0;
`endif
    localparam int L1 = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st  [2] = '{1'b0, 1'b0};
    logic       vld [2] = '{1'b0, 1'b0};
    logic [7:0] din [2] = '{8'h00, 8'h00};
    logic       rdy [2];
    logic       cin [2];
    logic       en  [2];
    logic       bsy [2];
    logic       dn  [2];
    logic       er  [2];

    always #5 clk = ~clk;

    config_loader #(.CHAIN_LENGTH(L0)) dut0 (
        .config_clock(clk), .config_reset(rst), .start(st[0]), .data_in(din[0]),
        .data_valid(vld[0]), .data_ready(rdy[0]), .config_in(cin[0]),
        .config_enable(en[0]), .busy(bsy[0]), .done(dn[0]), .error(er[0])
    );

    config_loader #(.CHAIN_LENGTH(L1)) dut1 (
        .config_clock(clk), .config_reset(rst), .start(st[1]), .data_in(din[1]),
        .data_valid(vld[1]), .data_ready(rdy[1]), .config_in(cin[1]),
        .config_enable(en[1]), .busy(bsy[1]), .done(dn[1]), .error(er[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: which bits of which accepted byte must appear, and when the handshake is open.
    int          len    [2] = '{L0, L1};
    bit          act_m  [2];
    bit          done_m [2];
    bit          err_m  [2];
    int          nbits  [2];
    int          pend   [2];
    int          bitpos [2];
    int          tcnt   [2];
    logic [7:0]  cur    [2];
    logic [7:0]  thi    [2];
    logic [15:0] crc_m  [2];
    int          en_cnt [2];
    logic [31:0] rec    [2];

    always @(negedge clk) begin
        bit e_en, e_busy, e_rdy, e_cin, acc, fb;
        for (int d = 0; d < 2; d++) begin
            e_en   = (pend[d] > 0);
            e_busy = act_m[d] && !done_m[d];
            e_rdy  = e_busy && !e_en;
            e_cin  = e_en ? cur[d][7 - bitpos[d]] : 1'b0;
            chk($sformatf("config_enable[%0d]", d), en[d], e_en);
            chk($sformatf("config_in[%0d]", d), cin[d], e_cin);
            chk($sformatf("data_ready[%0d]", d), rdy[d], e_rdy);
            chk($sformatf("busy[%0d]", d), bsy[d], e_busy);
            chk($sformatf("done[%0d]", d), dn[d], done_m[d]);
            chk($sformatf("error[%0d]", d), er[d], err_m[d]);
            if (en[d] === 1'b1) begin
                en_cnt[d]++;
                rec[d] = {rec[d][30:0], cin[d]};
            end
            acc = e_rdy && vld[d];
            if (e_en) begin
                fb       = crc_m[d][15] ^ e_cin;
                crc_m[d] = {crc_m[d][14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                nbits[d]++;
                bitpos[d]++;
                pend[d]--;
                if (nbits[d] == len[d] && !CRC_ON) done_m[d] = 1'b1;
            end else if (acc) begin
                if (nbits[d] < len[d]) begin
                    cur[d]    = din[d];
                    bitpos[d] = 0;
                    pend[d]   = (len[d] - nbits[d] < 8) ? len[d] - nbits[d] : 8;
                end else if (tcnt[d] == 0) begin
                    thi[d]  = din[d];
                    tcnt[d] = 1;
                end else begin
                    err_m[d]  = ({thi[d], din[d]} != crc_m[d]);
                    done_m[d] = 1'b1;
                end
            end
            if (st[d] && !e_busy) begin
                act_m[d] = 1'b1; done_m[d] = 1'b0; err_m[d] = 1'b0;
                nbits[d] = 0; pend[d] = 0; tcnt[d] = 0; crc_m[d] = 16'hFFFF;
                en_cnt[d] = 0; rec[d] = '0;
            end
            if (rst) begin
                act_m[d] = 1'b0; done_m[d] = 1'b0; err_m[d] = 1'b0;
                nbits[d] = 0; pend[d] = 0; tcnt[d] = 0;
            end
        end
    end

    task automatic start_pulse(input int d);
        @(posedge clk); #1 st[d] = 1'b1;
        @(posedge clk); #1 st[d] = 1'b0;
    endtask

    task automatic feed_byte(input int d, input logic [7:0] b, input int gap);
        bit ok;
        if (gap > 0) begin
            vld[d] = 1'b0;
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (rdy[d]) begin ok = 1'b1; break; end
            end
            chk("gap_ready_wait", ok, 1);
            repeat (gap) @(posedge clk);
            #1;
        end
        din[d] = b;
        vld[d] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (rdy[d]) begin ok = 1'b1; break; end
        end
        chk("handshake_wait", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int d);
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (dn[d]) begin ok = 1'b1; break; end
        end
        chk("done_wait", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic load(input int d, input logic [23:0] bytes, input int gap);
        start_pulse(d);
        feed_byte(d, bytes[23:16], 0);
        feed_byte(d, bytes[15:8], gap);
        feed_byte(d, bytes[7:0], gap);
        vld[d] = 1'b0;
        wait_done(d);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs0", {rdy[0], en[0], cin[0], bsy[0], dn[0], er[0]}, 0);
        chk("reset_outputs1", {rdy[1], en[1], cin[1], bsy[1], dn[1], er[1]}, 0);
`ifdef CONFIG_LOADER_CRC_EN
        load(0, 24'h31C782, 0);
        chk("crc_model_0x31", crc_m[0], 32'hC782);
        chk("crc_good_enables", en_cnt[0], 8);
        chk("crc_good_done", dn[0], 1);
        chk("crc_good_error", er[0], 0);
        load(0, 24'h31C783, 0);
        chk("crc_bad_done", dn[0], 1);
        chk("crc_bad_error", er[0], 1);
`else
        load(0, 24'hA50FC3, 0);
        chk("basic_stream", rec[0][23:0], 32'hA50FC3);
        chk("basic_enables", en_cnt[0], 24);
        chk("basic_done", dn[0], 1);
        chk("basic_busy", bsy[0], 0);
        repeat (4) @(posedge clk);
        #1 chk("done_held", dn[0], 1);

        load(1, 24'hFF00B7, 0);
        chk("partial_stream", rec[1][19:0], 32'hFF00B);
        chk("partial_enables", en_cnt[1], 20);
        chk("partial_done", dn[1], 1);

        load(0, 24'hA50FC3, 5);
        chk("gap_stream", rec[0][23:0], 32'hA50FC3);
        chk("gap_enables", en_cnt[0], 24);

        start_pulse(0);
        feed_byte(0, 8'hA5, 0);
        st[0] = 1'b1;
        @(posedge clk); #1 st[0] = 1'b0;
        feed_byte(0, 8'h0F, 0);
        feed_byte(0, 8'hC3, 0);
        vld[0] = 1'b0;
        wait_done(0);
        chk("start_ignored_stream", rec[0][23:0], 32'hA50FC3);
        chk("start_ignored_enables", en_cnt[0], 24);

        start_pulse(0);
        feed_byte(0, 8'hA5, 0);
        feed_byte(0, 8'h0F, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bits_before_reset", en_cnt[0], 10);
        rst    = 1'b1;
        vld[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midshift_reset_outputs", {rdy[0], en[0], cin[0], bsy[0], dn[0], er[0]}, 0);
        repeat (5) @(posedge clk);
        #1 chk("no_resume_busy", bsy[0], 0);
        load(0, 24'hA50FC3, 0);
        chk("restart_stream", rec[0][23:0], 32'hA50FC3);
        chk("restart_enables", en_cnt[0], 24);
        chk("restart_done", dn[0], 1);
`endif
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter CHAIN_LENGTH, default 216, meaning the total number of config bits in the downstream tile shift-register chain.
REQ-002 SHALL have port config_clock  input  1  the single clock; it also clocks the downstream config chain.
REQ-003 SHALL have port config_reset  input  1  synchronous reset, active-high.
REQ-004 SHALL have port start  input  1  a single-cycle request to begin a load.
REQ-005 SHALL have port data_in  input  8  the bitstream byte.
REQ-006 SHALL have port data_valid  input  1  the byte on data_in is valid.
REQ-007 SHALL have port data_ready  output  1  the loader accepts a byte this cycle.
REQ-008 SHALL have port config_in  output  1  the serial bit driven into the first tile's config_in.
REQ-009 SHALL have port config_enable  output  1  the shift enable for the entire chain.
REQ-010 SHALL have port busy  output  1  a load is in progress.
REQ-011 SHALL have port done  output  1  the load has completed; held until the next start or reset.
REQ-012 SHALL have port error  output  1  CRC mismatch, valid while done is high.

Function
REQ-013 SHALL implement a state machine with states IDLE, LOAD, SHIFT, CRC and DONE.
REQ-014 IDLE/DONE: start=1 SHALL move to LOAD on the next edge, clear done and error, and zero the bit counter; start SHALL be ignored in LOAD, SHIFT and CRC.
REQ-015 LOAD: data_ready=1; a transfer occurs only when data_valid and data_ready are high on the same edge, which latches the byte into the shift register and moves the FSM to SHIFT.
REQ-016 SHIFT: config_enable=1 and config_in=shift_reg[7] (MSB first); one bit SHALL be shifted per cycle and the bit counter SHALL increment per cycle.
REQ-017 SHIFT SHALL leave after 8 bits (returning to LOAD), or as soon as the counter reaches CHAIN_LENGTH; whichever comes first wins.
REQ-018 When CHAIN_LENGTH is not a multiple of 8, the unused low bits of the final byte SHALL be discarded and never shifted.
REQ-019 config_enable SHALL be 0 in every state except SHIFT, so exactly CHAIN_LENGTH enable cycles occur per load.
REQ-020 config_in SHALL be 0 whenever config_enable=0.
REQ-021 busy SHALL be 1 in LOAD, SHIFT and CRC; data_ready SHALL be 1 only in LOAD or CRC.
REQ-022 There SHALL be no stall inside SHIFT; data_valid is don't-care there.
REQ-023 When the count reaches CHAIN_LENGTH, the FSM SHALL go to CRC (macro defined) or DONE (macro undefined) on the next edge.
REQ-024 The bit counter SHALL be ceil(log2(CHAIN_LENGTH+1)) bits wide and SHALL never wrap within a load.

Reset
REQ-025 config_reset=1 at any edge, including mid-SHIFT, SHALL force IDLE, clear the counter, shift register and CRC, and drive all outputs to 0 on that edge (config_enable=0, config_in=0, data_ready=0, busy=0, done=0, error=0).
REQ-026 A load interrupted by reset SHALL NOT resume; a new start is required.

Configuration
REQ-027 The macro CONFIG_LOADER_CRC_EN SHALL control CRC checking of the bitstream.
REQ-028 Defined: CRC-16-CCITT (polynomial 0x1021, init 0xFFFF, no reflection, no final XOR) SHALL be updated with each bit on config_in during SHIFT cycles.
REQ-029 Defined: the CRC state SHALL accept 2 trailer bytes through the same handshake, high byte first, then go to DONE with error=1 if the trailer differs from the computed CRC, else error=0.
REQ-030 Undefined: there SHALL be no CRC logic and no CRC state, and error SHALL be tied to 0.

Verification
REQ-031 CHAIN_LENGTH=24, bytes 0xA5,0x0F,0xC3 with data_valid always high -> config_enable high for exactly 24 cycles, serial stream 10100101 00001111 11000011, then done=1, busy=0.
REQ-032 CHAIN_LENGTH=20, bytes 0xFF,0x00,0xB7 -> 20 enable cycles, last four shifted bits 1011, low nibble 0111 never driven, done=1.
REQ-033 data_valid deasserted for 5 cycles between bytes -> config_enable=0 and the counter holds throughout the gap; the final stream matches the no-gap case.
REQ-034 config_reset=1 after 10 of 24 bits -> the next cycle has all outputs 0 in IDLE; a restart with start then reloads all 24 bits correctly.
REQ-035 With CONFIG_LOADER_CRC_EN, CHAIN_LENGTH=8, byte 0x31 followed by the correct 2-byte trailer -> done=1, error=0; the same byte with the last trailer byte flipped -> done=1, error=1.
REQ-036 A start pulse during SHIFT -> ignored, with no change to the counter or the stream.
